// File: rtl/mult_issue_if.sv
// Stream and multiplier-side signals of mult_issue. The master side is the
// environment (producer, multiplier, consumer); the slave side is mult_issue.
interface mult_issue_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_start;
  logic [WIDTH-1:0] mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_prod;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, mul_prod, out_ready,
    input  in_ready, mul_a, mul_b, mul_start, out_valid, out_prod, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, mul_prod, out_ready,
    output in_ready, mul_a, mul_b, mul_start, out_valid, out_prod, busy
  );
endinterface

// File: rtl/mult_issue.sv
// Operand FIFO + issue FSM wrapping the edge-triggered shift-add multiplier.
// Optional MULT_ISSUE_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_issue #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  mult_issue_if.slave io
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]   WLOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL  = CNTW'(DEPTH);

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_OUT} state_t;

  state_t            state_q, state_d;
  pair_t             mem_q [DEPTH];
  pair_t             mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;
  logic [WIDTH-1:0]  out_prod_q, out_prod_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready, push, pop;
  pair_t             head;

  // in_ready looks only at the registered count, never at a same-cycle pop
  assign in_ready = (count_q != FULL);
  assign push     = io.in_valid && in_ready;
  assign head     = mem_q[rptr_q];

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    wcnt_d      = wcnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    out_prod_d  = out_prod_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    if (push) begin
      mem_d[wptr_q] = '{a: io.in_a, b: io.in_b};
      wptr_d        = wptr_q + AW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop    = 1'b1;
          rptr_d = rptr_q + AW'(1);
          if (ZERO_BYPASS && (head.a == '0 || head.b == '0)) begin
            out_prod_d  = '0;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            mul_a_d = head.a;
            mul_b_d = head.b;
            state_d = S_SETUP;
          end
        end
      end
      // start is registered, so raising it here makes it high during START
      S_SETUP: begin
        mul_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        wcnt_d  = WLOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          out_prod_d  = io.mul_prod;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          wcnt_d = wcnt_q - CW'(1);
        end
      end
      S_OUT: begin
        if (out_valid_q && io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (!push && pop) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wcnt_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      out_prod_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      out_prod_q  <= out_prod_d;
      out_valid_q <= out_valid_d;
    end
  end

  // storage needs no reset: count/pointers gate every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io.in_ready  = in_ready;
  assign io.mul_a     = mul_a_q;
  assign io.mul_b     = mul_b_q;
  assign io.mul_start = mul_start_q;
  assign io.out_prod  = out_prod_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_mult_issue.sv
// Directed bench for mult_issue with a behavioural edge-triggered multiplier.
module tb_mult_issue;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nstart  = 0;

  mult_issue_if #(.WIDTH(W)) io();

  mult_issue #(.WIDTH(W), .DEPTH(4), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  // multiplier model: product settles on the rising start edge
  always @(posedge io.mul_start) begin
    io.mul_prod = io.mul_a * io.mul_b;
    nstart++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    io.in_a     = a;
    io.in_b     = b;
    io.in_valid = 1'b1;
    for (int i = 0; i < 40 && !io.in_ready; i++) tick();
    if (!io.in_ready) chk("push_timeout", 32'(io.in_ready), 32'd1);
    tick();
    io.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !io.out_valid; i++) tick();
    chk(tag, 32'(io.out_valid), 32'd1);
  endtask

  // expects out_ready high: checks the head result, then lets it be consumed
  task automatic collect(input logic [W-1:0] exp, input string tag);
    wait_valid({tag, "_vld"});
    chk(tag, 32'(io.out_prod), 32'(exp));
    tick();
  endtask

  initial begin
    int nst;
    int seen;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b0;

    // reset values
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(io.in_ready),  32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_prod",  32'(io.out_prod),  32'd0);
    chk("rst_mul_a",     32'(io.mul_a),     32'd0);
    chk("rst_mul_start", 32'(io.mul_start), 32'd0);
    chk("rst_busy",      32'(io.busy),      32'd0);

    // single pair 3*5, edge-exact timing
    io.out_ready = 1'b1;
    nst = nstart;
    push(16'd3, 16'd5);                                       // E0
    tick(); chk("e1_mul_a", 32'(io.mul_a), 32'd3);
    chk("e1_busy", 32'(io.busy), 32'd1);
    tick(); chk("e2_start_hi", 32'(io.mul_start), 32'd1);
    tick(); chk("e3_start_lo", 32'(io.mul_start), 32'd0);
    tick(); chk("e4_no_valid", 32'(io.out_valid), 32'd0);
    tick(); chk("e5_valid", 32'(io.out_valid), 32'd1);
    chk("e5_prod", 32'(io.out_prod), 32'd15);
    chk("e5_nstart", 32'(nstart - nst), 32'd1);
    tick(); chk("e6_consumed", 32'(io.out_valid), 32'd0);
    chk("e6_idle", 32'(io.busy), 32'd0);

    // back-pressure, then fill the FIFO behind a stalled result
    io.out_ready = 1'b0;
    nst = nstart;
    push(16'd2, 16'd3);
    wait_valid("bp_vld0");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(io.out_valid), 32'd1);
      chk("bp_prod",  32'(io.out_prod),  32'd6);
    end
    chk("bp_nstart", 32'(nstart - nst), 32'd1);
    push(16'd4, 16'd5);
    push(16'd6, 16'd7);
    push(16'd300, 16'd300);
    push(16'hFFFF, 16'd2);
    chk("full_ready", 32'(io.in_ready), 32'd0);
    io.in_a = 16'd9; io.in_b = 16'd9; io.in_valid = 1'b1;
    tick(); tick();
    chk("full_reject", 32'(io.in_ready), 32'd0);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    collect(16'd6,     "fill0");
    collect(16'd20,    "fill1");
    collect(16'd42,    "fill2");
    collect(16'd24464, "fill3");
    collect(16'd65534, "fill4");
    tick(); tick();
    chk("fill_drained", 32'(io.out_valid), 32'd0);
    chk("fill_busy",    32'(io.busy),      32'd0);
    chk("fill_nstart",  32'(nstart - nst), 32'd5);

    // wrap-around ordering with concurrent producer and consumer
    fork
      begin
        for (int k = 1; k <= 6; k++) push(16'(k), 16'd2);
      end
      begin
        for (int k = 1; k <= 6; k++) collect(16'(2 * k), "wrap");
      end
    join

    // simultaneous push and pop with two entries queued
    io.out_ready = 1'b0;
    push(16'd10, 16'd1);
    wait_valid("pp_vld0");
    chk("pp_prod0", 32'(io.out_prod), 32'd10);
    push(16'd11, 16'd1);
    push(16'd12, 16'd1);
    io.out_ready = 1'b1;
    tick();
    io.in_a = 16'd13; io.in_b = 16'd1; io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    chk("pp_count", 32'(dut.count_q), 32'd2);
    chk("pp_pop_a", 32'(io.mul_a), 32'd11);
    collect(16'd11, "pp1");
    collect(16'd12, "pp2");
    collect(16'd13, "pp3");

    // reset in WAIT discards queued work
    push(16'd7, 16'd7);
    push(16'd8, 16'd8);
    push(16'd9, 16'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mrst_start",     32'(io.mul_start), 32'd0);
    chk("mrst_in_ready",  32'(io.in_ready),  32'd1);
    chk("mrst_busy",      32'(io.busy),      32'd0);
    nst  = nstart;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (io.out_valid) seen++;
    end
    chk("mrst_no_result", 32'(seen), 32'd0);
    chk("mrst_no_start",  32'(nstart - nst), 32'd0);

    // zero operand
    nst = nstart;
    push(16'd0, 16'd7);                                       // E0
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    tick();
    chk("zero_valid_e1", 32'(io.out_valid), 32'd1);
    chk("zero_prod",     32'(io.out_prod),  32'd0);
    chk("zero_nstart",   32'(nstart - nst), 32'd0);
`else
    tick(); tick(); tick(); tick();
    chk("zero_no_valid_e4", 32'(io.out_valid), 32'd0);
    tick();
    chk("zero_valid_e5", 32'(io.out_valid), 32'd1);
    chk("zero_prod",     32'(io.out_prod),  32'd0);
    chk("zero_nstart",   32'(nstart - nst), 32'd1);
`endif
    tick();
    chk("zero_consumed", 32'(io.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_issue.md
# mult_issue

Operand-issue sequencer sitting directly upstream of the 16-bit shift-add multiplier `mult`. Accepts operand pairs over a valid/ready handshake into a small FIFO and presents them on the multiplier's `a`/`b` inputs. Generates the single rising `start` edge the multiplier triggers on, waits a programmable settle time, and returns the captured `prod` on a valid/ready output port. This converts the multiplier's edge-triggered, handshake-less interface into a clocked, back-pressurable stream stage.

## Interface
- `WIDTH`, 16: operand and product width; must match `mult`.
- `DEPTH`, 4: operand FIFO entries, power of two, ≥2.
- `WAIT_CYCLES`, 2: cycles between `mul_start` rising and product capture, ≥1.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `mul_a`  out  WIDTH  to `mult.a`, registered.
- `mul_b`  out  WIDTH  to `mult.b`, registered.
- `mul_start`  out  1  to `mult.start`, registered.
- `mul_prod`  in  WIDTH  from `mult.prod`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_prod`  out  WIDTH  registered product.
- `busy`  out  1  FSM not in IDLE or FIFO non-empty.

## Operation
- Reset: FIFO count 0, pointers 0, state IDLE. `in_ready`=1, `mul_a`=`mul_b`=0, `mul_start`=0, `out_valid`=0, `out_prod`=0, `busy`=0.
- FIFO push when `in_valid && in_ready`. `in_ready` = (count != DEPTH). It does not depend on a same-cycle pop, so there is no push when full even if a pop occurs. Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- FSM states: IDLE, SETUP, START, WAIT, OUT.
  - IDLE: if count != 0, pop head into `mul_a`/`mul_b` and go to SETUP. Otherwise stay.
  - SETUP: `mul_start`=0 for one cycle so operands are stable before the edge, then go to START.
  - START: `mul_start`=1 for exactly one cycle. Load the wait counter with WAIT_CYCLES−1. Go to WAIT.
  - WAIT: `mul_start`=0. Decrement the counter. When the counter is 0, register `out_prod`<=`mul_prod`, set `out_valid`<=1, and go to OUT.
  - OUT: hold `out_prod`/`out_valid` stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- Push and pop in the same cycle leave count unchanged.
- Exactly one `mul_start` rising edge per popped pair. `mul_a`/`mul_b` hold from the pop until the next pop.
- Products are truncated to WIDTH exactly as `mult` produces them; no extra arithmetic is done here.
- Reset asserted mid-operation (any state) discards FIFO contents and any in-flight result. Outputs return to reset values on that edge, and `mul_start` is low from that edge onward.

## Timing
- Pair accepted at edge E0 into an empty FIFO in IDLE: pop at E1, SETUP during E1–E2, `mul_start` high during E2–E3, `out_valid` rises at E(3+WAIT_CYCLES). With defaults that is E5.
- Throughput: one result per WAIT_CYCLES+4 cycles when `out_ready` is held high (consumer accepts in the first OUT cycle, IDLE pops on the next edge).
- `out_prod` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `MULT_ISSUE_ZERO_BYPASS_EN`:
  - Defined: in IDLE, a popped pair with `a`==0 or `b`==0 skips SETUP/START/WAIT and goes straight to OUT with `out_prod`=0, `out_valid` high at the pop edge. `mul_a`/`mul_b`/`mul_start` are not updated and no start edge is generated.
  - Undefined: every pair, including zero operands, takes the full path.

## Test plan
- Reset then single pair a=3, b=5, `out_ready`=1 -> one `mul_start` pulse of one cycle; `out_valid` at E5; `out_prod`=15 for a correct `mult` model.
- Fill: 4 pairs pushed back-to-back, `out_ready`=0 -> `in_ready` drops after the 4th; a 5th push is not accepted. Then `out_ready`=1 -> 4 results in order, 1 `mul_start` per result.
- Back-pressure: `out_ready` held 0 for 10 cycles after `out_valid` -> `out_prod` and `out_valid` constant; no new `mul_start`.
- Simultaneous push/pop with count=2 -> count stays 2; wrap-around after 6 pushes gives correct order (a=1..6).
- Reset asserted during WAIT -> next edge `out_valid`=0, `mul_start`=0, `in_ready`=1, `busy`=0; previously queued pairs never produce results.
- Zero operand a=0, b=7: with `MULT_ISSUE_ZERO_BYPASS_EN`, `out_prod`=0 at E1 with no `mul_start`. Without the macro, `out_prod`=0 at E5 after one `mul_start` pulse.
